// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// operation encoding, configuration legality and group-to-stage slicing helpers.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  localparam int GROUP_BITS = 4;

  function automatic bit cfg_legal(input int width, input int stages);
    return (width >= 8) && (width <= 64) && ((width % GROUP_BITS) == 0) &&
           (stages >= 1) && (stages <= width / GROUP_BITS);
  endfunction

  // First group index owned by stage s; slice_lo(groups, stages, stages) == groups.
  function automatic int slice_lo(input int groups, input int stages, input int s);
    return (stages > 0) ? (s * groups) / stages : 0;
  endfunction

  function automatic int stage_of(input int groups, input int stages, input int g);
    int st;
    st = 0;
    for (int s = 1; s < stages; s++) begin
      if (slice_lo(groups, stages, s) <= g) st = s;
    end
    return st;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: sum bits plus group propagate/generate,
// which depend only on a and b so the next lookahead level never waits on cin.
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       p_out,
  output logic       g_out
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign s     = p ^ c;
  assign p_out = &p;
  assign g_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready flow control.
// Define ADDSUB_FLAGS_EN to build the signed-overflow and zero flags; otherwise they read 0.
module pipe_cla_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NG   = WIDTH / GROUP_BITS;
  localparam int LAST = STAGES - 1;

  if (!cfg_legal(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipe_cla_addsub: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
  end

  // Flat lookahead carry into group hi from a slice starting at group lo.
  function automatic logic la_carry(input logic [NG-1:0] p, input logic [NG-1:0] g,
                                    input int lo, input int hi, input logic cin);
    logic c;
    logic term;
    c = 1'b0;
    for (int k = lo; k < hi; k++) begin
      term = g[k];
      for (int j = k + 1; j < hi; j++) term = term & p[j];
      c = c | term;
    end
    term = cin;
    for (int j = lo; j < hi; j++) term = term & p[j];
    return c | term;
  endfunction

  function automatic logic [WIDTH-1:0] span_mask(input int lo, input int hi);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = GROUP_BITS * lo; i < GROUP_BITS * hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  logic adv;

  // Stage inputs (from the ports for stage 0, from the previous register otherwise).
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_b   [STAGES];
  logic [WIDTH-1:0]  st_s   [STAGES];
  logic [STAGES-1:0] st_c;
  logic [STAGES-1:0] st_v;
  logic [STAGES-1:0] st_cout;

  logic [WIDTH-1:0]  sum_d  [STAGES];
  logic [WIDTH-1:0]  a_d    [STAGES];
  logic [WIDTH-1:0]  b_d    [STAGES];

  logic [WIDTH-1:0]  sum_q  [STAGES];
  logic [WIDTH-1:0]  a_q    [STAGES];
  logic [WIDTH-1:0]  b_q    [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;

  logic [NG-1:0]     grp_p;
  logic [NG-1:0]     grp_g;
  logic [NG-1:0]     grp_cin;
  logic [WIDTH-1:0]  grp_sum;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = slice_lo(NG, STAGES, s);
    localparam int HI = slice_lo(NG, STAGES, s + 1);
    localparam logic [WIDTH-1:0] SLICE_M = span_mask(LO, HI);
    localparam logic [WIDTH-1:0] DONE_M  = span_mask(0, HI);

    if (s == 0) begin : g_src_in
      assign st_a[s] = in_a;
      assign st_b[s] = (in_op == OP_SUB) ? ~in_b : in_b;
      assign st_s[s] = '0;
      assign st_c[s] = (in_op == OP_SUB) ? 1'b1 : in_cin;
      assign st_v[s] = in_valid;
    end else begin : g_src_reg
      assign st_a[s] = a_q[s-1];
      assign st_b[s] = b_q[s-1];
      assign st_s[s] = sum_q[s-1];
      assign st_c[s] = c_q[s-1];
      assign st_v[s] = v_q[s-1];
    end

    assign st_cout[s] = la_carry(grp_p, grp_g, LO, HI, st_c[s]);
    assign sum_d[s]   = (st_s[s] & ~SLICE_M) | (grp_sum & SLICE_M);
    // Only operand bits of later slices travel on.
    assign a_d[s]     = st_a[s] & ~DONE_M;
    assign b_d[s]     = st_b[s] & ~DONE_M;
  end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    localparam int S  = stage_of(NG, STAGES, g);
    localparam int LO = slice_lo(NG, STAGES, S);

    cla_group4 u_grp (
      .a     (st_a[S][GROUP_BITS*g +: GROUP_BITS]),
      .b     (st_b[S][GROUP_BITS*g +: GROUP_BITS]),
      .cin   (grp_cin[g]),
      .s     (grp_sum[GROUP_BITS*g +: GROUP_BITS]),
      .p_out (grp_p[g]),
      .g_out (grp_g[g])
    );

    assign grp_cin[g] = la_carry(grp_p, grp_g, LO, g, st_c[S]);
  end

  // NOTE: data registers are reset too, so every result output reads 0 while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        v_q[s]   <= 1'b0;
        c_q[s]   <= 1'b0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
      end
    end else if (adv) begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
      for (int s = 0; s < STAGES; s++) begin
        v_q[s] <= st_v[s];
        if (st_v[s]) begin
          c_q[s]   <= st_cout[s];
          a_q[s]   <= a_d[s];
          b_q[s]   <= b_d[s];
          sum_q[s] <= sum_d[s];
        end
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = c_q[LAST];

`ifdef ADDSUB_FLAGS_EN
  logic msb_cin;
  logic ovf_d;
  logic zero_d;
  logic ovf_q;
  logic zero_q;

  // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin.
  assign msb_cin = st_a[LAST][WIDTH-1] ^ st_b[LAST][WIDTH-1] ^ grp_sum[WIDTH-1];
  assign ovf_d   = msb_cin ^ st_cout[LAST];
  assign zero_d  = ~|sum_d[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv && st_v[LAST]) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_ovf  = ovf_q;
  assign out_zero = zero_q;
`else
  assign out_ovf  = 1'b0;
  assign out_zero = 1'b0;
`endif

endmodule
